// File: rtl/ctrl_time_rec_7.sv
// Schedule recorder: captures each change of x as a (time, value) pair
// in entries 1..7. Each stored time is counter+1, which is the time the player replays at.
module ctrl_time_rec_7 #(
   parameter int DW = 64,
   parameter int NE = 7
) (
   input  logic          clk,
   input  logic          sta,
   input  logic [11:0]   counter,
   input  logic [DW-1:0] x,
   input  logic          en,
   input  logic          fin,
   output logic [11:0]   time_1,
   output logic [11:0]   time_2,
   output logic [11:0]   time_3,
   output logic [11:0]   time_4,
   output logic [11:0]   time_5,
   output logic [11:0]   time_6,
   output logic [11:0]   time_7,
   output logic [DW-1:0] value_1,
   output logic [DW-1:0] value_2,
   output logic [DW-1:0] value_3,
   output logic [DW-1:0] value_4,
   output logic [DW-1:0] value_5,
   output logic [DW-1:0] value_6,
   output logic [DW-1:0] value_7,
   output logic [2:0]    cnt,
   output logic          rdy,
   output logic          ovf
);

   // state   | meaning
   // ST_REC  | watching x, storing changes into the next free entry
   // ST_DONE | table closed; all inputs ignored until reset
   typedef enum logic {ST_REC, ST_DONE} state_t;

   localparam logic [2:0]  CNT_MAX = 3'(NE);
   localparam logic [11:0] CTR_TOP = 12'hFFF;

   state_t        state_q, state_d;
   logic [DW-1:0] last_q, last_d;
   logic [11:0]   time_q  [NE];
   logic [11:0]   time_d  [NE];
   logic [DW-1:0] value_q [NE];
   logic [DW-1:0] value_d [NE];
   logic [2:0]    cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          rdy_q, rdy_d;
   logic          chg;
   logic          room;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      time_d  = time_q;
      value_d = value_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;

      chg  = (state_q == ST_REC) && en && (x != last_q);
      // A stored time of 0 would never fire in the player, so counter 4095 cannot be recorded
      room = (cnt_q < CNT_MAX) && (counter != CTR_TOP);

      if (chg) begin
         last_d = x;
         if (room) begin
            for (int k = 0; k < NE; k++) begin
               if (cnt_q == 3'(k)) begin
                  time_d[k]  = counter + 12'd1;
                  value_d[k] = x;
               end
            end
            cnt_d = cnt_q + 3'd1;
         end else begin
            ovf_d = 1'b1;
         end
      end

      if ((state_q == ST_REC) && fin) begin
         state_d = ST_DONE;
      end
      rdy_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!sta) begin
         state_q <= ST_REC;
         last_q  <= '0;
         for (int k = 0; k < NE; k++) begin
            time_q[k]  <= '0;
            value_q[k] <= '0;
         end
         cnt_q <= '0;
         ovf_q <= 1'b0;
         rdy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         time_q  <= time_d;
         value_q <= value_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         rdy_q   <= rdy_d;
      end
   end

   assign time_1  = time_q[0];
   assign time_2  = time_q[1];
   assign time_3  = time_q[2];
   assign time_4  = time_q[3];
   assign time_5  = time_q[4];
   assign time_6  = time_q[5];
   assign time_7  = time_q[6];
   assign value_1 = value_q[0];
   assign value_2 = value_q[1];
   assign value_3 = value_q[2];
   assign value_4 = value_q[3];
   assign value_5 = value_q[4];
   assign value_6 = value_q[5];
   assign value_7 = value_q[6];
   assign cnt     = cnt_q;
   assign rdy     = rdy_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_ctrl_time_rec_7.sv
// Bench for ctrl_time_rec_7: queue-based recorder model checked every cycle,
// literal pins per scenario, and a replay through a 7-entry player model.
module tb_ctrl_time_rec_7;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          sta = 1'b1;
   logic [11:0]   counter = '0;
   logic [DW-1:0] x = '0;
   logic          en = 1'b0;
   logic          fin = 1'b0;
   logic [11:0]   t_o [7];
   logic [DW-1:0] v_o [7];
   logic [2:0]    cnt;
   logic          rdy;
   logic          ovf;

   ctrl_time_rec_7 #(.DW(DW), .NE(7)) dut (
      .clk(clk), .sta(sta), .counter(counter), .x(x), .en(en), .fin(fin),
      .time_1(t_o[0]), .time_2(t_o[1]), .time_3(t_o[2]), .time_4(t_o[3]),
      .time_5(t_o[4]), .time_6(t_o[5]), .time_7(t_o[6]),
      .value_1(v_o[0]), .value_2(v_o[1]), .value_3(v_o[2]), .value_4(v_o[3]),
      .value_5(v_o[4]), .value_6(v_o[5]), .value_7(v_o[6]),
      .cnt(cnt), .rdy(rdy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;
   bit replay_on = 1'b0;

   // recorder model: list of stored events plus last seen value
   logic [11:0]   m_time [$];
   logic [DW-1:0] m_val [$];
   logic [DW-1:0] m_last;
   bit            m_ovf;
   bit            m_done;

   logic [DW-1:0] x_at [32];

   localparam logic [DW-1:0] VA = 64'hA5A5_0000_1111_2222;
   localparam logic [DW-1:0] VB = 64'h0123_4567_89AB_CDEF;
   localparam logic [DW-1:0] VC = 64'h0000_0000_0000_00C3;
   localparam logic [DW-1:0] VD = 64'hDDDD_0000_0000_0001;
   localparam logic [DW-1:0] VE = 64'hEEEE_EEEE_0000_0000;
   localparam logic [DW-1:0] VF = 64'hFFFF_0000_FFFF_0000;
   localparam logic [DW-1:0] VG = 64'h7777_0000_0000_7777;
   localparam logic [DW-1:0] VH = 64'h0000_8888_8888_0000;
   localparam logic [DW-1:0] V1 = 64'h0000_0000_0000_0011;
   localparam logic [DW-1:0] V2 = 64'h0000_0000_0000_0022;
   localparam logic [DW-1:0] V3 = 64'h8000_0000_0000_0033;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] exp_time(input int k);
      return (k < m_time.size()) ? m_time[k] : 12'd0;
   endfunction

   function automatic logic [DW-1:0] exp_val(input int k);
      return (k < m_val.size()) ? m_val[k] : '0;
   endfunction

   task automatic model_edge(input bit s, input logic [11:0] c, input logic [DW-1:0] xv,
                             input bit e, input bit f);
      if (!s) begin
         m_time.delete();
         m_val.delete();
         m_last = '0;
         m_ovf  = 1'b0;
         m_done = 1'b0;
      end else if (!m_done) begin
         if (e && (xv != m_last)) begin
            m_last = xv;
            if (m_time.size() < 7 && c != 12'd4095) begin
               m_time.push_back(12'((int'(c) + 1) % 4096));
               m_val.push_back(xv);
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (f) m_done = 1'b1;
      end
   endtask

   task automatic step(input logic [11:0] c, input logic [DW-1:0] xv, input bit e,
                       input bit f, input bit s = 1'b1);
      counter = c;
      x       = xv;
      en      = e;
      fin     = f;
      sta     = s;
      @(posedge clk);
      model_edge(s, c, xv, e, f);
      @(negedge clk);
   endtask

   task automatic do_reset();
      step(12'd0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 7; k++) begin
            check($sformatf("time_%0d", k + 1), DW'(t_o[k]), DW'(exp_time(k)));
            check($sformatf("value_%0d", k + 1), v_o[k], exp_val(k));
         end
         check("cnt", DW'(cnt), DW'(m_time.size()));
         check("rdy", DW'(rdy), DW'(m_done));
         check("ovf", DW'(ovf), DW'(m_ovf));
      end
   end

   // player model: output reaches value_k two edges after counter == time_k-1
   int            p_idx = 0;
   bit            p_hit = 1'b0;
   logic [DW-1:0] p_pend = '0;
   logic [DW-1:0] p_out = '0;

   always @(posedge clk) begin
      if (!replay_on) begin
         p_idx  <= 0;
         p_hit  <= 1'b0;
         p_out  <= '0;
      end else begin
         if (counter >= 12'd2 && counter <= 12'd22)
            check("replay", p_out, x_at[int'(counter) - 2]);
         if (p_idx < 7 && t_o[p_idx] != 12'd0 && counter == t_o[p_idx] - 12'd1) begin
            p_pend <= v_o[p_idx];
            p_hit  <= 1'b1;
            p_idx  <= p_idx + 1;
         end else begin
            p_hit <= 1'b0;
         end
         if (p_hit) p_out <= p_pend;
      end
   end

   initial begin
      m_last = '0;
      m_ovf  = 1'b0;
      m_done = 1'b0;
      @(negedge clk);
      chk_on = 1'b1;

      // basic capture
      do_reset();
      check("reset cnt", DW'(cnt), 64'd0);
      check("reset time_1", DW'(t_o[0]), 64'd0);
      for (int c = 0; c <= 32; c++)
         step(12'(c), (c >= 20) ? VB : (c >= 10) ? VA : '0, 1'b1, c == 30);
      check("basic time_1", DW'(t_o[0]), 64'd11);
      check("basic value_1", v_o[0], VA);
      check("basic time_2", DW'(t_o[1]), 64'd21);
      check("basic value_2", v_o[1], VB);
      check("basic time_3", DW'(t_o[2]), 64'd0);
      check("basic cnt", DW'(cnt), 64'd2);
      check("basic rdy", DW'(rdy), 64'd1);
      check("basic ovf", DW'(ovf), 64'd0);

      // overflow
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         step(12'(c), 64'h1000 + DW'(c), 1'b1, 1'b0);
         if (c == 7) check("ovf before 8th", DW'(ovf), 64'd0);
      end
      check("ovf cnt", DW'(cnt), 64'd7);
      check("ovf time_1", DW'(t_o[0]), 64'd2);
      check("ovf time_7", DW'(t_o[6]), 64'd8);
      check("ovf value_7", v_o[6], 64'h1007);
      check("ovf flag", DW'(ovf), 64'd1);
      step(12'd9, 64'h1008, 1'b1, 1'b0);
      check("ovf sticky", DW'(ovf), 64'd1);

      // boundary time
      do_reset();
      step(12'd4094, '0, 1'b1, 1'b0);
      step(12'd4095, VG, 1'b1, 1'b0);
      check("bnd cnt", DW'(cnt), 64'd0);
      check("bnd ovf", DW'(ovf), 64'd1);
      step(12'd0, VH, 1'b1, 1'b0);
      check("bnd time_1", DW'(t_o[0]), 64'd1);
      check("bnd value_1", v_o[0], VH);

      // enable gating
      do_reset();
      step(12'd40, '0, 1'b1, 1'b0);
      step(12'd41, VC, 1'b0, 1'b0);
      step(12'd42, '0, 1'b0, 1'b0);
      step(12'd43, '0, 1'b1, 1'b0);
      check("gate cnt", DW'(cnt), 64'd0);
      step(12'd50, VD, 1'b1, 1'b0);
      check("gate time_1", DW'(t_o[0]), 64'd51);
      check("gate value_1", v_o[0], VD);

      // simultaneous change and close
      do_reset();
      step(12'd4, '0, 1'b1, 1'b0);
      step(12'd5, VE, 1'b1, 1'b1);
      check("sim time_1", DW'(t_o[0]), 64'd6);
      check("sim value_1", v_o[0], VE);
      check("sim rdy", DW'(rdy), 64'd1);
      step(12'd9, VF, 1'b1, 1'b0);
      step(12'd10, VA, 1'b1, 1'b1);
      check("sim hold cnt", DW'(cnt), 64'd1);
      check("sim hold value_1", v_o[0], VE);

      // mid-run reset, then record and replay
      do_reset();
      step(12'd1, VA, 1'b1, 1'b0);
      step(12'd2, VB, 1'b1, 1'b0);
      step(12'd3, VC, 1'b1, 1'b0);
      check("mid cnt before", DW'(cnt), 64'd3);
      do_reset();
      check("mid cnt", DW'(cnt), 64'd0);
      check("mid time_3", DW'(t_o[2]), 64'd0);
      check("mid value_1", v_o[0], 64'd0);
      for (int c = 0; c < 32; c++)
         x_at[c] = (c >= 15) ? V3 : (c >= 10) ? V2 : (c >= 5) ? V1 : '0;
      for (int c = 0; c <= 20; c++)
         step(12'(c), x_at[c], 1'b1, c == 20);
      check("rt time_1", DW'(t_o[0]), 64'd6);
      check("rt time_3", DW'(t_o[2]), 64'd16);
      replay_on = 1'b1;
      for (int c = 0; c <= 24; c++)
         step(12'(c), '0, 1'b0, 1'b0);
      check("rt final out", p_out, V3);
      replay_on = 1'b0;

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
